// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: datapath width, default reset PC,
// and the fetch FSM state encodings.
package pc_fetch_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCF_RESET = 2'd0,
    PCF_FETCH = 2'd1,
    PCF_EXEC  = 2'd2,
    PCF_TRAP  = 2'd3
  } pcf_state_t;
endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-PC selection: sequential PC+4 or branch/JAL/JALR target,
// plus detection of a taken target that is not 4-byte aligned.
module pc_target_gen
  import pc_fetch_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  jalr,
  input  logic                  take,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  misaligned
);
  localparam logic [DATA_WIDTH-1:0] FOUR      = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] CLEAR_LSB = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  logic [DATA_WIDTH-1:0] target;

  always_comb begin
    // JALR clears bit 0 of the sum; bit 1 can still leave the target misaligned.
    target     = jalr ? ((rs1 + imm) & CLEAR_LSB) : (pc + imm);
    next_pc    = take ? target : (pc + FOUR);
    misaligned = take && (target[1:0] != 2'b00);
  end
endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: fetches one instruction per
// request/ack exchange, holds it during EXEC, then commits PC+4 or a target.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_take,
  input  logic                  i_jalr,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic                  i_stall,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_instr_valid,
  output logic                  o_trap,
  output logic [31:0]           o_retired,
  output logic [1:0]            o_state
);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  // Handshake: o_imem_req is held high with o_imem_addr stable until the
  // first cycle i_imem_ack is sampled high at a rising edge; that edge
  // transfers i_imem_rdata and ends the request. Acks at any other time are
  // ignored.
  pcf_state_t state, next_state;

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [31:0]           retired_q;
  logic                  req_q;
  logic                  valid_q;
  logic                  trap_q;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  misaligned;
  logic                  commit;

  pc_target_gen u_target (
    .pc         (pc_q),
    .rs1        (i_rs1),
    .imm        (i_imm),
    .jalr       (i_jalr),
    .take       (i_take),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      PCF_RESET: next_state = PCF_FETCH;
      PCF_FETCH: if (i_imem_ack) next_state = PCF_EXEC;
      PCF_EXEC: begin
        if (!i_stall) begin
          if (misaligned) begin
            next_state = PCF_TRAP;
          end else begin
            next_state = PCF_FETCH;
            commit     = 1'b1;
          end
        end
      end
      PCF_TRAP:  next_state = PCF_TRAP;
      default:   next_state = PCF_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= PCF_RESET;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state   <= next_state;
      req_q   <= (next_state == PCF_FETCH);
      valid_q <= (next_state == PCF_EXEC);
      if (state == PCF_FETCH && i_imem_ack) begin
        instr_q <= i_imem_rdata;
      end
      if (commit) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 32'd1;
      end
      if (next_state == PCF_TRAP) begin
        trap_q <= 1'b1;
      end
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + FOUR;
  assign o_instr       = instr_q;
  assign o_instr_valid = valid_q;
  assign o_trap        = trap_q;
  assign o_retired     = retired_q;
  assign o_state       = state;
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed and random instruction streams checked by a
// scoreboard fed from a PC/retire-count model of the fetch stage.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        take = 1'b0, jalr = 1'b0, stall = 1'b0, ack = 1'b0;
  logic [31:0] rs1 = '0, imm = '0, rdata = '0;
  logic        req, valid, trap;
  logic [31:0] addr, pc, pc4, instr, retired;
  logic [1:0]  state;

  logic        rst_n_w = 1'b0, ack_w = 1'b0;
  logic        w_req, w_valid, w_trap;
  logic [31:0] w_addr, w_pc, w_pc4, w_instr, w_ret;
  logic [1:0]  w_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_instr_q[$];
  logic [63:0] exp_trap_q[$];
  logic [31:0] m_pc, m_ret;

  pc_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_take(take), .i_jalr(jalr), .i_rs1(rs1),
    .i_imm(imm), .i_stall(stall), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata), .o_pc(pc), .o_pc_plus4(pc4),
    .o_instr(instr), .o_instr_valid(valid), .o_trap(trap),
    .o_retired(retired), .o_state(state)
  );

  pc_fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .i_rst_n(rst_n_w), .i_take(take), .i_jalr(jalr), .i_rs1(rs1),
    .i_imm(imm), .i_stall(stall), .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_ack(ack_w), .i_imem_rdata(rdata), .o_pc(w_pc), .o_pc_plus4(w_pc4),
    .o_instr(w_instr), .o_instr_valid(w_valid), .o_trap(w_trap),
    .o_retired(w_ret), .o_state(w_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a new fetch, instruction or trap
  logic req_d = 1'b0, valid_d = 1'b0, trap_d = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] ei;
    if (rst_n) begin
      if (req && !req_d) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch", addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("fetch_addr", addr, e[63:32]);
          check("fetch_pc", pc, e[63:32]);
          check("fetch_pc_plus4", pc4, e[63:32] + 32'd4);
          check("fetch_retired", retired, e[31:0]);
          check("fetch_valid_low", {31'd0, valid}, 32'd0);
        end
      end
      if (valid && !valid_d) begin
        if (exp_instr_q.size() == 0) begin
          check("unexpected_exec", instr, ~instr);
        end else begin
          ei = exp_instr_q.pop_front();
          check("exec_instr", instr, ei);
          check("exec_req_low", {31'd0, req}, 32'd0);
        end
      end
      if (trap && !trap_d) begin
        if (exp_trap_q.size() == 0) begin
          check("unexpected_trap", {31'd0, trap}, 32'd0);
        end else begin
          e = exp_trap_q.pop_front();
          check("trap_pc", pc, e[63:32]);
          check("trap_retired", retired, e[31:0]);
          check("trap_req_low", {31'd0, req}, 32'd0);
          check("trap_valid_low", {31'd0, valid}, 32'd0);
        end
      end
    end
    req_d   = req;
    valid_d = valid;
    trap_d  = trap;
  end

  // driver tasks
  task automatic scramble();
    take  = 1'($urandom);
    jalr  = 1'($urandom);
    stall = 1'($urandom);
    rs1   = $urandom;
    imm   = $urandom;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    ack   = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc4, 32'h4);
    check("rst_instr", instr, 32'h0);
    check("rst_flags", {28'd0, req, valid, trap, 1'b0}, 32'h0);
    check("rst_retired", retired, 32'h0);
    repeat (2) @(negedge clk);
    check("queues_drained", 32'(exp_q.size() + exp_instr_q.size() + exp_trap_q.size()), 32'd0);
    exp_q.delete();
    exp_instr_q.delete();
    exp_trap_q.delete();
    m_pc  = 32'h0;
    m_ret = 32'h0;
    exp_q.push_back({m_pc, m_ret});
    rst_n = 1'b1;
    @(negedge clk);
    check("req_after_release", {31'd0, req}, 32'd1);
    check("addr_after_release", addr, 32'h0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req) begin
        ok = 1'b1;
        break;
      end
      ack = 1'b0;
      scramble();
      @(negedge clk);
    end
    if (!ok) check("req_timeout", {31'd0, req}, 32'd1);
  endtask

  task automatic do_instr(input int dly, input logic t, input logic j,
                          input logic [31:0] r, input logic [31:0] im,
                          input int stalls, input bit abort, output bit trapped);
    bit ok;
    logic [31:0] a0, w, target;
    trapped = 1'b0;
    wait_req(ok);
    if (!ok) begin
      trapped = 1'b1;
      return;
    end
    a0 = addr;
    for (int d = 0; d < dly; d++) begin
      ack = 1'b0;
      scramble();
      @(negedge clk);
      check("req_held", {31'd0, req}, 32'd1);
      check("addr_stable", addr, a0);
    end
    w = $urandom;
    rdata = w;
    ack = 1'b1;
    exp_instr_q.push_back(w);
    @(negedge clk);
    ack   = 1'($urandom);
    rdata = $urandom;
    if (abort) begin
      do_reset();
      return;
    end
    take = t; jalr = j; rs1 = r; imm = im;
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      @(negedge clk);
      check("stall_valid", {31'd0, valid}, 32'd1);
      check("stall_pc", pc, m_pc);
      check("stall_retired", retired, m_ret);
      check("exec_ack_ignored", instr, w);
      ack   = 1'($urandom);
      rdata = $urandom;
    end
    stall = 1'b0;
    target = j ? ((r + im) & 32'hFFFF_FFFE) : (m_pc + im);
    if (t && (target % 4 != 0)) begin
      exp_trap_q.push_back({m_pc, m_ret});
      trapped = 1'b1;
    end else begin
      m_pc  = t ? target : m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
      exp_q.push_back({m_pc, m_ret});
    end
    @(negedge clk);
    ack = 1'b0;
    scramble();
  endtask

  task automatic trap_idle();
    for (int i = 0; i < 3; i++) begin
      ack = 1'($urandom);
      scramble();
      @(negedge clk);
      check("trap_req_stays_low", {31'd0, req}, 32'd0);
      check("trap_sticky", {31'd0, trap}, 32'd1);
      check("trap_pc_frozen", pc, m_pc);
    end
    do_reset();
  endtask

  initial begin
    bit tr;
    int dly, stalls;
    logic t, j;
    logic [31:0] r, im;

    // reset vector at the top of the address space wraps to 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n_w = 1'b1;
    @(negedge clk);
    check("wrap_req", {31'd0, w_req}, 32'd1);
    check("wrap_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", w_pc4, 32'h0);
    ack_w = 1'b1;
    @(negedge clk);
    ack_w = 1'b0;
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    take = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_retired", w_ret, 32'd1);

    do_reset();
    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, tr);
    check("first_commit_pc", pc, 32'h4);
    check("first_commit_retired", retired, 32'd1);
    do_instr(3, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, tr);
    do_instr(1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF8, 0, 1'b0, tr);
    check("branch_back_pc", pc, 32'h0);
    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, tr);
    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, tr);
    do_instr(0, 1'b1, 1'b1, 32'h101, 32'h2, 0, 1'b0, tr);
    check("jalr_trapped", {31'd0, tr}, 32'd1);
    trap_idle();
    do_instr(2, 1'b1, 1'b1, 32'h105, 32'hFFFF_FFFF, 2, 1'b0, tr);
    check("jalr_aligned_pc", pc, 32'h104);
    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, tr);

    for (int n = 0; n < 200; n++) begin
      dly    = $urandom_range(0, 3);
      stalls = $urandom_range(0, 2);
      t      = 1'($urandom);
      j      = ($urandom_range(0, 3) == 0);
      r      = $urandom;
      if ($urandom_range(0, 7) == 0) im = 32'($urandom_range(0, 255)) - 32'd128;
      else                           im = (32'($urandom_range(0, 63)) - 32'd32) << 2;
      do_instr(dly, t, j, r, im, stalls, ($urandom_range(0, 24) == 0), tr);
      if (tr) trap_idle();
    end

    repeat (3) @(negedge clk);
    check("final_instr_q_empty", 32'(exp_instr_q.size() + exp_trap_q.size()), 32'd0);
    check("final_fetch_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage of the core: owns the architectural PC, fetches each instruction from instruction memory over a request/acknowledge handshake, and holds it stable while the datapath executes. Sits directly downstream of `branch_unit`: consumes its `o_take` plus the jump/branch operands and commits the next PC (PC+4 or target) once per instruction. A retired-instruction counter and a sticky misaligned-target trap are included.

## Interface
- Reset, fixed: one clock; reset is asynchronous and active-low.
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `clk` input 1: sole clock, rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_take` input 1: `branch_unit.o_take` for the instruction in EXEC.
- `i_jalr` input 1: 1 means the target is register-relative (JALR).
- `i_rs1` input `DATA_WIDTH`: rs1 value for JALR.
- `i_imm` input `DATA_WIDTH`: sign-extended immediate (branch/JAL/JALR offset).
- `i_stall` input 1: 1 holds EXEC and blocks commit.
- `o_imem_req` output 1: fetch request.
- `o_imem_addr` output `DATA_WIDTH`: fetch address, equal to `o_pc`.
- `i_imem_ack` input 1: read data valid this cycle.
- `i_imem_rdata` input `DATA_WIDTH`: instruction word.
- `o_pc` output `DATA_WIDTH`: current PC.
- `o_pc_plus4` output `DATA_WIDTH`: `o_pc`+4, used for JAL/JALR link.
- `o_instr` output `DATA_WIDTH`: latched instruction.
- `o_instr_valid` output 1: 1 only in EXEC.
- `o_trap` output 1: sticky misaligned-target trap.
- `o_retired` output 32: committed-instruction count.

## Operation
- States: RESET, FETCH, EXEC, TRAP.
- RESET is entered asynchronously while `i_rst_n`=0. It moves to FETCH at the first rising edge with `i_rst_n`=1.
- FETCH: `o_imem_req`=1. On `i_imem_ack`=1: latch `i_imem_rdata` into `o_instr` and go to EXEC. Otherwise stay.
- EXEC: `o_instr_valid`=1. With `i_stall`=1, hold everything. With `i_stall`=0, commit at the edge:
  - Target when `i_jalr`=1: (`i_rs1`+`i_imm`) & ~1.
  - Target when `i_jalr`=0: `o_pc`+`i_imm`.
  - next_pc = `i_take` ? target : `o_pc`+4.
  - If `i_take`=1 and target[1:0]≠0: PC unchanged, `o_retired` unchanged, `o_trap`←1, go to TRAP.
  - Otherwise: `o_pc`←next_pc, `o_retired`++, go to FETCH.
- TRAP: all requests deasserted. Exit only via reset.
- Arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. `o_retired` wraps from 2^32−1 to 0.
- `i_imem_ack` is ignored outside FETCH. `i_take`, `i_stall` and the operands are ignored outside EXEC.

## Timing
- Reset values: `o_pc`=`RESET_VECTOR`, `o_pc_plus4`=`RESET_VECTOR`+4, `o_instr`=0, `o_instr_valid`=0, `o_imem_req`=0, `o_trap`=0, `o_retired`=0.
- `o_imem_req` rises one cycle after reset release.
- Fetch latency: ack in the same cycle as the request gives EXEC on the next cycle. Minimum throughput is 2 cycles per instruction (FETCH, EXEC).
- `o_imem_addr` is stable from request until ack. The request never drops before ack.
- New PC is visible the cycle after commit, with `o_imem_req` asserted in that same cycle.
- `o_pc_plus4` is combinational from `o_pc`. All other outputs are registered.
- Reset asserted mid-fetch or mid-EXEC: immediate return to reset values. A pending ack is dropped.

## Structure
- Shared defines header (next to the `BRANCH_*` codes and `DATA_WIDTH`): state encodings `PCF_RESET`, `PCF_FETCH`, `PCF_EXEC`, `PCF_TRAP`, and the default `RESET_VECTOR`.
- One combinational sub-module, `pc_target_gen`: inputs pc, rs1, imm, jalr, take. Outputs next_pc and misaligned.
- The FSM, PC register, instruction latch and counter live in `pc_fetch`.

## Test plan
- Reset release, ack same cycle: `o_imem_addr`=0 one cycle after release, `o_instr_valid`=1 the next cycle. No-take commit gives `o_pc`=4, `o_retired`=1.
- Ack delayed 3 cycles: `o_imem_req` held and address stable for 4 cycles. Ack in EXEC is ignored.
- Branch at PC 8 with `i_take`=1, `i_imm`=−8: `o_pc`=0 next. JALR with `i_rs1`=0x101, `i_imm`=2 gives `o_pc`=0x102 → trap, `o_pc` stays 8, `o_retired` unchanged.
- JALR with `i_rs1`=0x105, `i_imm`=−1: target 0x104, no trap. `i_stall`=1 for 2 cycles in EXEC holds PC and the counter.
- `RESET_VECTOR`=32'hFFFF_FFFC, no take: `o_pc` wraps to 0.
- `i_rst_n` pulsed low mid-EXEC and mid-TRAP: all outputs return to reset values immediately. `o_trap` clears.
